ti2_out_map_col: RTL and testbench



---
 rtl/ti_aes_pkg.sv | 16 +
 rtl/ti_out_lin_map.sv | 35 +++
 rtl/ti2_out_map_col.sv | 138 +++++++++++++
 tb/tb_ti2_out_map_col.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ti_aes_pkg.sv
// rtl/ti_aes_pkg.sv - shared constants and types for the 2-share AES S-box datapath
package ti_aes_pkg;

  localparam int SHARE_W = 8;
  localparam int NLANES  = 4;
  localparam int LANE_W  = $clog2(NLANES);
  localparam int FILL_W  = (NLANES - 1) * SHARE_W;
  localparam int COL_W   = NLANES * SHARE_W;

  localparam logic [SHARE_W-1:0] AFFINE_C_DEF = 8'h63;

  typedef logic [LANE_W-1:0] lane_t;

  localparam lane_t LAST_LANE = lane_t'(NLANES - 1);

endpackage

// File: rtl/ti_out_lin_map.sv
// rtl/ti_out_lin_map.sv - one share of the output linear map: inverse basis change then AES affine
module ti_out_lin_map
  import ti_aes_pkg::*;
#(
  parameter logic [SHARE_W-1:0] AFFINE_C = AFFINE_C_DEF
) (
  input  logic [SHARE_W-1:0] b,
  input  logic               c_en,
  output logic [SHARE_W-1:0] o
);

  logic [SHARE_W-1:0] a;
  logic [SHARE_W-1:0] rot4, rot5, rot6, rot7;

  always_comb begin
    a    = '0;
    a[0] = b[2];
    a[1] = b[5] ^ b[1];
    a[4] = b[6] ^ b[1];
    a[7] = b[4] ^ b[1];
    a[2] = b[7] ^ b[5] ^ b[4] ^ b[1];
    a[3] = b[6] ^ b[5] ^ b[4] ^ b[3] ^ b[2] ^ b[1];
    a[5] = b[7] ^ b[6] ^ b[5] ^ b[3] ^ b[2] ^ b[0];
    a[6] = b[7] ^ b[6] ^ b[5] ^ b[3] ^ b[1] ^ b[0];
  end

  // Right rotation by k puts a[i+k] at bit i, which is the affine row pattern.
  assign rot4 = {a[3:0], a[7:4]};
  assign rot5 = {a[4:0], a[7:5]};
  assign rot6 = {a[5:0], a[7:6]};
  assign rot7 = {a[6:0], a[7]};

  assign o = a ^ rot4 ^ rot5 ^ rot6 ^ rot7 ^ ({SHARE_W{c_en}} & AFFINE_C);

endmodule

// File: rtl/ti2_out_map_col.sv
// rtl/ti2_out_map_col.sv - 2-share S-box output map and 4-byte column packer
module ti2_out_map_col
  import ti_aes_pkg::*;
#(
  parameter logic [SHARE_W-1:0] AFFINE_C = AFFINE_C_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [SHARE_W-1:0] in_s0,
  input  logic [SHARE_W-1:0] in_s1,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [COL_W-1:0]   out_s0,
  output logic [COL_W-1:0]   out_s1,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SHARE_W-1:0] map_s0, map_s1;

  logic [SHARE_W-1:0] s1_s0_q, s1_s0_d;
  logic [SHARE_W-1:0] s1_s1_q, s1_s1_d;
  logic               s1_valid_q, s1_valid_d;
  lane_t              cnt_q, cnt_d;
  logic [FILL_W-1:0]  fill_s0_q, fill_s0_d;
  logic [FILL_W-1:0]  fill_s1_q, fill_s1_d;
  logic [COL_W-1:0]   out_s0_q, out_s0_d;
  logic [COL_W-1:0]   out_s1_q, out_s1_d;
  logic               out_valid_q, out_valid_d;

  logic s1_take;
  logic in_fire;

  ti_out_lin_map #(.AFFINE_C(AFFINE_C)) u_map_s0 (
    .b    (in_s0),
    .c_en (1'b1),
    .o    (map_s0)
  );

  ti_out_lin_map #(.AFFINE_C(AFFINE_C)) u_map_s1 (
    .b    (in_s1),
    .c_en (1'b0),
    .o    (map_s1)
  );

  assign s1_take  = s1_valid_q && ((cnt_q != LAST_LANE) || !out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_take;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    s1_s0_d     = s1_s0_q;
    s1_s1_d     = s1_s1_q;
    s1_valid_d  = s1_valid_q;
    cnt_d       = cnt_q;
    fill_s0_d   = fill_s0_q;
    fill_s1_d   = fill_s1_q;
    out_s0_d    = out_s0_q;
    out_s1_d    = out_s1_q;
    out_valid_d = out_valid_q;

    // A consumed column is wiped; a lane-3 take below may overwrite it the same cycle.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_s0_d    = '0;
      out_s1_d    = '0;
    end

    if (clear) begin
      s1_valid_d = 1'b0;
      cnt_d      = '0;
      fill_s0_d  = '0;
      fill_s1_d  = '0;
    end else begin
      if (s1_take) begin
        if (cnt_q == LAST_LANE) begin
          out_s0_d    = {s1_s0_q, fill_s0_q};
          out_s1_d    = {s1_s1_q, fill_s1_q};
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          case (cnt_q)
            2'd0: begin
              fill_s0_d[7:0] = s1_s0_q;
              fill_s1_d[7:0] = s1_s1_q;
            end
            2'd1: begin
              fill_s0_d[15:8] = s1_s0_q;
              fill_s1_d[15:8] = s1_s1_q;
            end
            default: begin
              fill_s0_d[23:16] = s1_s0_q;
              fill_s1_d[23:16] = s1_s1_q;
            end
          endcase
          cnt_d = cnt_q + lane_t'(1);
        end
      end

      if (in_fire) begin
        s1_s0_d    = map_s0;
        s1_s1_d    = map_s1;
        s1_valid_d = 1'b1;
      end else if (s1_take) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_s0_q     <= '0;
      s1_s1_q     <= '0;
      s1_valid_q  <= 1'b0;
      cnt_q       <= '0;
      fill_s0_q   <= '0;
      fill_s1_q   <= '0;
      out_s0_q    <= '0;
      out_s1_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_s0_q     <= s1_s0_d;
      s1_s1_q     <= s1_s1_d;
      s1_valid_q  <= s1_valid_d;
      cnt_q       <= cnt_d;
      fill_s0_q   <= fill_s0_d;
      fill_s1_q   <= fill_s1_d;
      out_s0_q    <= out_s0_d;
      out_s1_q    <= out_s1_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_s0    = out_s0_q;
  assign out_s1    = out_s1_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ti2_out_map_col.sv
// tb/tb_ti2_out_map_col.sv - self-checking bench for ti2_out_map_col
module tb_ti2_out_map_col;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [7:0]  in_s0, in_s1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_s0, out_s1;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  pend0[$], pend1[$];
  logic [31:0] exp0[$], exp1[$];

  ti2_out_map_col dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_s0     (in_s0),
    .in_s1     (in_s1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_s0    (out_s0),
    .out_s1    (out_s1),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] n_ref(input logic [7:0] b);
    logic [7:0] a;
    a[0] = b[2];
    a[1] = b[5] ^ b[1];
    a[4] = b[6] ^ b[1];
    a[7] = b[4] ^ b[1];
    a[2] = b[7] ^ b[5] ^ b[4] ^ b[1];
    a[3] = b[6] ^ b[5] ^ b[4] ^ b[3] ^ b[2] ^ b[1];
    a[5] = b[7] ^ b[6] ^ b[5] ^ b[3] ^ b[2] ^ b[0];
    a[6] = b[7] ^ b[6] ^ b[5] ^ b[3] ^ b[1] ^ b[0];
    return a;
  endfunction

  function automatic logic [7:0] l_ref(input logic [7:0] a);
    logic [7:0] o;
    for (int i = 0; i < 8; i++)
      o[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8] ^ a[(i + 7) % 8];
    return o;
  endfunction

  function automatic logic [31:0] col_ref(input logic [31:0] raw, input bit first);
    logic [31:0] c;
    for (int k = 0; k < 4; k++)
      c[8*k +: 8] = l_ref(n_ref(raw[8*k +: 8])) ^ (first ? 8'h63 : 8'h00);
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] s0, input logic [7:0] s1);
    int waited;
    waited   = 0;
    in_s0    = s0;
    in_s1    = s1;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!in_ready) check("push_ready_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_col(input logic [31:0] r0, input logic [31:0] r1);
    for (int k = 0; k < 4; k++) push(r0[8*k +: 8], r1[8*k +: 8]);
  endtask

  // Scoreboard: every four accepted bytes since reset/clear form the next expected column.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pend0.delete(); pend1.delete();
      exp0.delete();  exp1.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp0.size() == 0) begin
          check("col_unexpected", 32'(out_valid), 32'd0);
        end else begin
          check("col_s0", out_s0, exp0.pop_front());
          check("col_s1", out_s1, exp1.pop_front());
        end
      end
      if (clear) begin
        pend0.delete(); pend1.delete();
      end else if (in_valid && in_ready) begin
        pend0.push_back(in_s0);
        pend1.push_back(in_s1);
        if (pend0.size() == 4) begin
          exp0.push_back(col_ref({pend0[3], pend0[2], pend0[1], pend0[0]}, 1'b1));
          exp1.push_back(col_ref({pend1[3], pend1[2], pend1[1], pend1[0]}, 1'b0));
          pend0.delete(); pend1.delete();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] vec, m, ra, rb, rc, h0, h1;
    int start;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_s0 = '0; in_s1 = '0;
    vec = 32'h0098FF00;
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_s0", out_s0, 32'd0);
    check("rst_out_s1", out_s1, 32'd0);
    rst = 1'b0;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Unshared vector, with exact latency
    push_col(vec, 32'd0);
    check("vec_latency_early", 32'(out_valid), 32'd0);
    step();
    check("vec_latency", 32'(out_valid), 32'd1);
    check("vec_s0", out_s0, col_ref(vec, 1'b1));
    check("vec_s1", out_s1, 32'd0);
    step();

    // Random 2-sharings of the same bytes
    for (int r = 0; r < 3; r++) begin
      m = $urandom;
      push_col(vec ^ m, m);
      step();
      check("share_latency", 32'(out_valid), 32'd1);
      check("share_unmask", out_s0 ^ out_s1, col_ref(vec, 1'b1));
      step();
    end

    // Full throughput: 12 random bytes back to back
    start = cyc;
    for (int r = 0; r < 3; r++) push_col($urandom, $urandom);
    check("throughput_cycles", 32'(cyc - start), 32'd12);
    step(); step();

    // Backpressure: two columns offered with the output stalled
    out_ready = 1'b0;
    ra = $urandom; rb = $urandom; rc = $urandom; m = $urandom;
    push_col(ra, m);
    push_col(rb, rc);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_s0", out_s0, col_ref(ra, 1'b1));
    check("bp_hold_s1", out_s1, col_ref(m, 1'b0));
    in_s0 = 8'hA5; in_s1 = 8'h5A; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_stall_ready", 32'(in_ready), 32'd0);
      check("bp_stall_s0", out_s0, col_ref(ra, 1'b1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_swap_valid", 32'(out_valid), 32'd1);
    check("bp_swap_s0", out_s0, col_ref(rb, 1'b1));
    check("bp_swap_s1", out_s1, col_ref(rc, 1'b0));
    step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // clear after two bytes drops them and the byte offered during clear
    push($urandom, $urandom);
    push($urandom, $urandom);
    in_s0 = 8'h3C; in_s1 = 8'hC3; in_valid = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    ra = $urandom; rb = $urandom;
    push_col(ra, rb);
    step();
    check("clr_fresh_valid", 32'(out_valid), 32'd1);
    check("clr_fresh_s0", out_s0, col_ref(ra, 1'b1));
    check("clr_fresh_s1", out_s1, col_ref(rb, 1'b0));
    step();

    // clear leaves a held output column untouched
    out_ready = 1'b0;
    h0 = $urandom; h1 = $urandom;
    push_col(h0, h1);
    push($urandom, $urandom);
    push($urandom, $urandom);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_held_valid", 32'(out_valid), 32'd1);
    check("clr_held_s0", out_s0, col_ref(h0, 1'b1));
    check("clr_held_s1", out_s1, col_ref(h1, 1'b0));
    out_ready = 1'b1;
    ra = $urandom; rb = $urandom;
    push_col(ra, rb);
    step();
    check("clr_after_s0", out_s0, col_ref(ra, 1'b1));
    check("clr_after_s1", out_s1, col_ref(rb, 1'b0));
    step();

    // Reset mid-column with a held output column
    out_ready = 1'b0;
    push_col($urandom, $urandom);
    push($urandom, $urandom);
    push($urandom, $urandom);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_s0", out_s0, 32'd0);
    check("mrst_out_s1", out_s1, 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    ra = $urandom; rb = $urandom;
    push_col(ra, rb);
    step();
    check("mrst_next_s0", out_s0, col_ref(ra, 1'b1));
    check("mrst_next_s1", out_s1, col_ref(rb, 1'b0));
    step(); step();

    check("cols_outstanding", 32'(exp0.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
